// File: rtl/cpu_mem_loader.sv
// Boot/load engine: turns a header+payload word stream into imem/dmem/regfile writes
// and runs the CPU under a cycle budget. Optional trailer checksum: LOADER_CHECKSUM_EN.
module cpu_mem_loader #(
    parameter int XLEN    = 32,
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8,
    parameter int RF_AW   = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [XLEN-1:0]    s_data,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic               rf_we,
    output logic [RF_AW-1:0]   rf_addr,
    output logic [XLEN-1:0]    rf_wdata,
    input  logic               cpu_halt,
    output logic               cpu_run,
    output logic               done,
    output logic               timeout,
    output logic [CNT_W-1:0]   run_cycles,
    output logic               chk_err
);

    localparam int AW_ID  = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
    localparam int AW_MAX = (AW_ID > RF_AW) ? AW_ID : RF_AW;

    localparam logic [AW_MAX-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0]  CYC_ONE = 1;
    localparam logic [13:0]       REM_ONE = 1;
    localparam logic [15:0]       BUD_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CHK  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic                live_reg;
    logic [1:0]          tgt_reg, tgt_next;
    logic [13:0]         remain_reg, remain_next;
    logic [AW_MAX-1:0]   ptr_reg, ptr_next;
    logic [15:0]         budget_reg, budget_next;
    logic [CNT_W-1:0]    cyc_reg, cyc_next;
    logic                timeout_reg, timeout_next;
    logic                done_reg, done_next;
    logic [2:0]          we_reg, we_next;
    logic [AW_MAX-1:0]   waddr_reg, waddr_next;
    logic [XLEN-1:0]     wdata_reg, wdata_next;
    logic                accept;
    logic [1:0]          hdr_tgt;
    logic [13:0]         hdr_cnt;
    logic [15:0]         hdr_lo;
`ifdef LOADER_CHECKSUM_EN
    logic [XLEN-1:0]     xacc_reg, xacc_next;
    logic                chk_err_reg, chk_err_next;
`endif

    // live_reg holds s_ready low until the first edge after reset release
    assign s_ready = live_reg && (state_reg != ST_RUN);
    assign accept  = s_valid && s_ready;
    assign cpu_run = (state_reg == ST_RUN);
    assign hdr_tgt = s_data[31:30];
    assign hdr_cnt = s_data[29:16];
    assign hdr_lo  = s_data[15:0];

    always_comb begin
        state_next   = state_reg;
        tgt_next     = tgt_reg;
        remain_next  = remain_reg;
        ptr_next     = ptr_reg;
        budget_next  = budget_reg;
        cyc_next     = cyc_reg;
        timeout_next = timeout_reg;
        done_next    = 1'b0;
        we_next      = 3'b000;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;
`ifdef LOADER_CHECKSUM_EN
        xacc_next    = xacc_reg;
        chk_err_next = chk_err_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_tgt == 2'b11) begin
                        state_next   = ST_RUN;
                        budget_next  = hdr_lo;
                        cyc_next     = '0;
                        timeout_next = 1'b0;
                    end else begin
                        tgt_next    = hdr_tgt;
                        remain_next = hdr_cnt;
                        ptr_next    = hdr_lo[AW_MAX-1:0];
`ifdef LOADER_CHECKSUM_EN
                        xacc_next   = '0;
                        state_next  = (hdr_cnt != 14'd0) ? ST_LOAD : ST_CHK;
`else
                        state_next  = (hdr_cnt != 14'd0) ? ST_LOAD : ST_IDLE;
`endif
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    case (tgt_reg)
                        2'b00:   we_next = 3'b001;
                        2'b01:   we_next = 3'b010;
                        default: we_next = 3'b100;
                    endcase
                    waddr_next  = ptr_reg;
                    wdata_next  = s_data;
                    ptr_next    = ptr_reg + PTR_ONE;
                    remain_next = remain_reg - REM_ONE;
`ifdef LOADER_CHECKSUM_EN
                    xacc_next   = xacc_reg ^ s_data;
                    if (remain_reg == REM_ONE) state_next = ST_CHK;
`else
                    if (remain_reg == REM_ONE) state_next = ST_IDLE;
`endif
                end
            end
            ST_CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    if (s_data != xacc_reg) chk_err_next = 1'b1;
                    state_next = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            default: begin
                if (cyc_reg != '1) cyc_next = cyc_reg + CYC_ONE;
                if (budget_reg != 16'd0) budget_next = budget_reg - BUD_ONE;
                // halt has priority over a simultaneous budget expiry
                if (cpu_halt) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (budget_reg == BUD_ONE) begin
                    done_next    = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            live_reg    <= 1'b0;
            tgt_reg     <= 2'b00;
            remain_reg  <= '0;
            ptr_reg     <= '0;
            budget_reg  <= '0;
            cyc_reg     <= '0;
            timeout_reg <= 1'b0;
            done_reg    <= 1'b0;
            we_reg      <= 3'b000;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
`ifdef LOADER_CHECKSUM_EN
            xacc_reg    <= '0;
            chk_err_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            live_reg    <= 1'b1;
            tgt_reg     <= tgt_next;
            remain_reg  <= remain_next;
            ptr_reg     <= ptr_next;
            budget_reg  <= budget_next;
            cyc_reg     <= cyc_next;
            timeout_reg <= timeout_next;
            done_reg    <= done_next;
            we_reg      <= we_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
`ifdef LOADER_CHECKSUM_EN
            xacc_reg    <= xacc_next;
            chk_err_reg <= chk_err_next;
`endif
        end
    end

    // One shared address/data register; each target sees its own address width.
    assign imem_we    = we_reg[0];
    assign dmem_we    = we_reg[1];
    assign rf_we      = we_reg[2];
    assign imem_addr  = waddr_reg[IMEM_AW-1:0];
    assign dmem_addr  = waddr_reg[DMEM_AW-1:0];
    assign rf_addr    = waddr_reg[RF_AW-1:0];
    assign imem_wdata = wdata_reg;
    assign dmem_wdata = wdata_reg;
    assign rf_wdata   = wdata_reg;
    assign done       = done_reg;
    assign timeout    = timeout_reg;
    assign run_cycles = cyc_reg;
`ifdef LOADER_CHECKSUM_EN
    assign chk_err    = chk_err_reg;
`else
    assign chk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Scoreboard bench for cpu_mem_loader: driver pushes expected writes/run results,
// a negedge monitor pops and compares whenever the DUT strobes a write or done.
module tb_cpu_mem_loader;
    localparam int IMEM_AW = 8;
    localparam int DMEM_AW = 8;
    localparam int RF_AW   = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        imem_we, dmem_we, rf_we;
    logic [7:0]  imem_addr, dmem_addr;
    logic [4:0]  rf_addr;
    logic [31:0] imem_wdata, dmem_wdata, rf_wdata;
    logic        cpu_halt = 1'b0;
    logic        cpu_run, done, timeout, chk_err;
    logic [15:0] run_cycles;

    cpu_mem_loader #(.XLEN(32), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW), .RF_AW(RF_AW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .cpu_halt(cpu_halt), .cpu_run(cpu_run), .done(done), .timeout(timeout),
        .run_cycles(run_cycles), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    typedef struct { int tgt; int addr; logic [31:0] data; int cyc; } wr_t;
    typedef struct { int tmo; int cycles; } run_t;

    wr_t         exp_wr[$];
    run_t        exp_run[$];
    logic [31:0] pay[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          run_cnt = 0;
    logic        exp_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: checks every write strobe and every done pulse against the queues.
    always @(negedge clk) begin : mon
        int n, t, a;
        logic [31:0] d;
        wr_t e;
        run_t r;
        if (reset) begin
            n = int'(imem_we) + int'(dmem_we) + int'(rf_we);
            if (n > 1) begin
                checks++; errors++;
                $display("FAIL multi_we actual=%0d required=1", n);
            end
            if (n >= 1) begin
                t = imem_we ? 0 : (dmem_we ? 1 : 2);
                a = imem_we ? int'(imem_addr) : (dmem_we ? int'(dmem_addr) : int'(rf_addr));
                d = imem_we ? imem_wdata : (dmem_we ? dmem_wdata : rf_wdata);
                $display("wr tgt=%0d addr=%0h data=%0h cyc=%0d", t, a, d, cyc);
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write actual=tgt%0d/%0h/%0h required=none", t, a, d);
                end else begin
                    e = exp_wr.pop_front();
                    if (t != e.tgt || a != e.addr || d != e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write actual=tgt%0d a%0h d%0h c%0d required=tgt%0d a%0h d%0h c%0d",
                                 t, a, d, cyc, e.tgt, e.addr, e.data, e.cyc);
                    end
                end
            end
            if (cpu_run) run_cnt++;
            if (done) begin
                $display("done timeout=%0d run_cycles=%0d run_high=%0d", timeout, run_cycles, run_cnt);
                if (exp_run.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_done actual=1 required=0");
                end else begin
                    r = exp_run.pop_front();
                    chk("run_timeout", {31'd0, timeout}, r.tmo);
                    chk("run_cycles", {16'd0, run_cycles}, r.cycles);
                    chk("run_high_cycles", run_cnt, r.cycles);
                    chk("ready_in_done", {31'd0, s_ready}, 1);
                    chk("run_low_in_done", {31'd0, cpu_run}, 0);
                end
                run_cnt = 0;
            end
        end
    end

    task automatic send_word(input logic [31:0] w, input int gap, output int acc);
        int t;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk); s_valid = 1'b0;
        end
        @(negedge clk); s_valid = 1'b1; s_data = w;
        t = 0;
        while (!s_ready && t < 300) begin
            @(negedge clk); t++;
        end
        if (t >= 300) begin
            checks++; errors++;
            $display("FAIL ready_wait actual=0 required=1");
        end
        acc = cyc + 1;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic do_load(input int tgt, input int base, input int gap, input logic bad);
        int acc, aw, cnt;
        logic [31:0] x, hdr;
        cnt = pay.size();
        aw = (tgt == 0) ? IMEM_AW : ((tgt == 1) ? DMEM_AW : RF_AW);
        hdr = {tgt[1:0], cnt[13:0], base[15:0]};
        $display("load tgt=%0d cnt=%0d base=%0h", tgt, cnt, base);
        send_word(hdr, gap, acc);
        x = '0;
        for (int i = 0; i < cnt; i++) begin
            send_word(pay[i], gap, acc);
            exp_wr.push_back('{tgt, (base + i) % (1 << aw), pay[i], acc});
            x = x ^ pay[i];
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(bad ? (x ^ 32'hFF) : x, gap, acc);
        if (bad) exp_chk = 1'b1;
        chk("chk_err", {31'd0, chk_err}, {31'd0, exp_chk});
`else
        if (bad) x = ~x;
        chk("chk_err_tied", {31'd0, chk_err}, 0);
`endif
        pay.delete();
    endtask

    task automatic do_run(input int b, input int h);
        int et, ec, acc, n;
        logic fin;
        if (h > 0 && (b == 0 || h <= b)) begin et = 0; ec = h; end
        else begin et = 1; ec = b; end
        exp_run.push_back('{et, ec});
        $display("run budget=%0d halt_at=%0d", b, h);
        send_word({2'b11, 14'd0, b[15:0]}, 0, acc);
        chk("run_starts", {31'd0, cpu_run}, 1);
        chk("timeout_cleared", {31'd0, timeout}, 0);
        n = 0; fin = 1'b0;
        while (!fin && n < ec + 5) begin
            @(negedge clk); n++;
            cpu_halt = (n == h);
            if (done) fin = 1'b1;
        end
        cpu_halt = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL done_wait actual=0 required=1");
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 0);
        chk({tag, "_cpu_run"}, {31'd0, cpu_run}, 0);
        chk({tag, "_we"}, {29'd0, imem_we, dmem_we, rf_we}, 0);
        chk({tag, "_addr_data"}, imem_addr | dmem_addr | rf_addr | imem_wdata | dmem_wdata | rf_wdata, 0);
        chk({tag, "_status"}, {16'd0, run_cycles} | {done, timeout, chk_err}, 0);
    endtask

    initial begin
        int acc, tgt, cnt, base, gap;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", {31'd0, s_ready}, 1);

        pay = '{32'h00221800, 32'h04222000, 32'h8CA60004, 32'hACA60008, 32'h08000001};
        do_load(0, 0, 0, 1'b0);
        pay = '{32'd100, 32'd200};
        do_load(1, 16'h00FF, 0, 1'b0);
        pay = '{32'd10, 32'd5};
        do_load(2, 1, 1, 1'b0);

        do_run(20, 0);
        repeat (2) @(negedge clk);
        chk("timeout_sticky_idle", {31'd0, timeout}, 1);
        pay = '{32'h1234};
        do_load(1, 3, 0, 1'b0);
        chk("timeout_sticky_load", {31'd0, timeout}, 1);
        do_run(20, 7);
        do_run(20, 20);
        do_run(0, 30);
        do_run(1, 0);

        for (int k = 0; k < 10; k++) begin
            tgt  = $urandom_range(0, 2);
            cnt  = $urandom_range(0, 6);
            base = $urandom_range(0, 65535);
            gap  = $urandom_range(0, 2);
            for (int i = 0; i < cnt; i++) pay.push_back($urandom);
            do_load(tgt, base, gap, 1'b0);
        end

        pay = '{32'h0F, 32'hF0};
        do_load(1, 0, 0, 1'b0);
        pay = '{32'h0F, 32'hF0};
        do_load(1, 0, 0, 1'b1);
        pay = '{32'hAA};
        do_load(2, 4, 0, 1'b0);
        pay.delete();
        do_load(0, 9, 0, 1'b0);

        // Partial load abandoned by reset; the words already written are expected.
        pay = '{32'h11, 32'h22};
        send_word({2'b01, 14'd4, 16'd10}, 0, acc);
        for (int i = 0; i < 2; i++) begin
            send_word(pay[i], 0, acc);
            exp_wr.push_back('{1, 10 + i, pay[i], acc});
        end
        pay.delete();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 reset_checks("reset_mid_load");
        exp_chk = 1'b0;
        @(negedge clk); reset = 1'b1;
        pay = '{32'h33};
        do_load(0, 7, 0, 1'b0);

        // Reset mid-RUN must drop cpu_run without waiting for a clock edge.
        send_word({2'b11, 14'd0, 16'd50}, 0, acc);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1 reset_checks("reset_mid_run");
        run_cnt = 0;
        @(negedge clk); reset = 1'b1;
        do_run(5, 0);

        repeat (5) @(negedge clk);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("run_queue_empty", exp_run.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
